// File: rtl/config_frame_sequencer.sv
// config_frame_sequencer: turns a synced stream of 32-bit configuration words into
// column frame writes (address word, NumberOfRows data words, one-cycle strobe).
module config_frame_sequencer #(
    parameter int NumberOfRows = 16,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int FrameSelectWidth = 5,
    parameter int DesyncFlag = 20,
    parameter logic [31:0] SyncWord = 32'hFAB0_FAB1
) (
    input  logic                                    CLK,
    input  logic                                    resetn,
    input  logic [31:0]                             WriteData,
    input  logic                                    WriteStrobe,
    output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]              FrameAddress,
    output logic [FrameSelectWidth-1:0]             FrameSelect,
    output logic                                    FrameStrobe,
    output logic                                    Synced,
    output logic                                    ConfigError
);
    localparam int RowW = $clog2(NumberOfRows);

    typedef enum logic [1:0] {UNSYNC, ADDR, DATA, STROBE} state_t;

    state_t state, nextState;
    logic [RowW-1:0] rowCnt;
    logic [FrameSelectWidth-1:0] column;
    logic [7:0] frameIdx;
    logic frameValid;
    logic addrWord, dataWord, lastWord, idxOk;

    assign addrWord = WriteStrobe && (state == ADDR || state == STROBE) && !WriteData[DesyncFlag];
    assign dataWord = WriteStrobe && state == DATA;
    assign lastWord = dataWord && rowCnt == RowW'(NumberOfRows - 1);
    assign idxOk = WriteData[7:0] < 8'(MaxFramesPerCol);

    always_comb begin
        nextState = state;
        unique case (state)
            UNSYNC: nextState = (WriteStrobe && WriteData == SyncWord) ? ADDR : UNSYNC;
            ADDR: nextState = !WriteStrobe ? ADDR : WriteData[DesyncFlag] ? UNSYNC : DATA;
            DATA: nextState = lastWord ? STROBE : DATA;
            // a word arriving during the strobe is already the next address word
            STROBE: nextState = !WriteStrobe ? ADDR : WriteData[DesyncFlag] ? UNSYNC : DATA;
            default: nextState = UNSYNC;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= UNSYNC;
            rowCnt <= '0;
            column <= '0;
            frameIdx <= '0;
            frameValid <= 1'b0;
            FrameData <= '0;
            FrameAddress <= '0;
            FrameSelect <= '0;
            FrameStrobe <= 1'b0;
            Synced <= 1'b0;
            ConfigError <= 1'b0;
        end else begin
            state <= nextState;
            Synced <= nextState != UNSYNC;
            FrameStrobe <= lastWord && frameValid;
            FrameAddress <= (lastWord && frameValid) ? MaxFramesPerCol'(1) << frameIdx : '0;
            if (lastWord)
                FrameSelect <= column;
            if (addrWord) begin
                column <= WriteData[31:32-FrameSelectWidth];
                frameIdx <= WriteData[7:0];
                frameValid <= idxOk;
                rowCnt <= '0;
                if (!idxOk)
                    ConfigError <= 1'b1;
            end
            if (dataWord) begin
                FrameData[rowCnt*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData;
                rowCnt <= lastWord ? '0 : rowCnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_config_frame_sequencer.sv
// tb_config_frame_sequencer: scoreboard bench; expected strobes are queued as frames are sent.
module tb_config_frame_sequencer;
    localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;

    typedef struct {
        logic [4:0]   sel;
        logic [19:0]  addr;
        logic [511:0] data;
    } exp_t;

    logic CLK = 1'b0;
    logic resetn = 1'b0;
    logic [31:0] WriteData = '0;
    logic WriteStrobe = 1'b0;
    logic [511:0] FrameData;
    logic [19:0] FrameAddress;
    logic [4:0] FrameSelect;
    logic FrameStrobe, Synced, ConfigError;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    exp_t q[$];
    int strobeCycles[$];
    logic [511:0] modelData = '0;

    config_frame_sequencer dut (
        .CLK(CLK), .resetn(resetn), .WriteData(WriteData), .WriteStrobe(WriteStrobe),
        .FrameData(FrameData), .FrameAddress(FrameAddress), .FrameSelect(FrameSelect),
        .FrameStrobe(FrameStrobe), .Synced(Synced), .ConfigError(ConfigError)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle++;

    always @(negedge CLK) begin
        exp_t e;
        if (FrameStrobe) begin
            strobeCycles.push_back(cycle);
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe sel=%0d addr=%h", FrameSelect, FrameAddress);
            end else begin
                e = q.pop_front();
                if ({FrameSelect, FrameAddress, FrameData} !== {e.sel, e.addr, e.data}) begin
                    bad++;
                    $display("FAIL strobe_content sel=%0d/%0d addr=%h/%h data=%h/%h",
                             FrameSelect, e.sel, FrameAddress, e.addr, FrameData, e.data);
                end
            end
        end else begin
            total++;
            if (FrameAddress !== 20'h0) begin
                bad++;
                $display("FAIL addr_outside_strobe got=%h want=0", FrameAddress);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic put(input logic [31:0] w);
        WriteData = w;
        WriteStrobe = 1'b1;
        @(posedge CLK);
        #1 WriteStrobe = 1'b0;
    endtask

    task automatic sendFrame(input logic [31:0] addr, input logic [31:0] base, input bit live);
        exp_t e;
        put(addr);
        for (int k = 0; k < 16; k++) begin
            if (live)
                modelData[32*k +: 32] = base + k;
            if (k == 15 && live && addr[7:0] < 8'd20) begin
                e.sel = addr[31:27];
                e.addr = 20'(1) << addr[7:0];
                e.data = modelData;
                q.push_back(e);
            end
            put(base + k);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        int n;
        resetn = 1'b0;
        idle(3);
        total++;
        if ({FrameData, FrameAddress, FrameSelect, FrameStrobe, Synced, ConfigError} !== '0) begin
            bad++;
            $display("FAIL reset_values got sel=%0d addr=%h synced=%b err=%b", FrameSelect, FrameAddress, Synced, ConfigError);
        end
        resetn = 1'b1;
        idle(1);
        n = strobeCycles.size();
        for (int k = 0; k < 16; k++) put(32'h1234_5678);
        idle(2);
        total++;
        if (Synced !== 1'b0 || FrameData !== '0 || strobeCycles.size() != n) begin
            bad++;
            $display("FAIL unsynced_ignore synced=%b strobes=%0d want 0/0", Synced, strobeCycles.size() - n);
        end
    endtask

    task automatic test_single;
        put(SyncWord);
        total++;
        if (Synced !== 1'b1) begin
            bad++;
            $display("FAIL sync_enter got=%b want=1", Synced);
        end
        sendFrame(32'h1800_0003, 32'h0, 1'b1);
        total++;
        if (FrameStrobe !== 1'b1) begin
            bad++;
            $display("FAIL strobe_latency got=%b want=1", FrameStrobe);
        end
        idle(1);
        total++;
        if (FrameStrobe !== 1'b0 || FrameSelect !== 5'd3 || FrameData[32*5 +: 32] !== 32'd5) begin
            bad++;
            $display("FAIL after_strobe strobe=%b sel=%0d row5=%h want 0/3/5", FrameStrobe, FrameSelect, FrameData[32*5 +: 32]);
        end
        idle(2);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL single_missing got=%0d pending want=0", q.size());
        end
    endtask

    task automatic test_back_to_back;
        int n;
        n = strobeCycles.size();
        sendFrame(32'h0800_0000, 32'h100, 1'b1);
        sendFrame(32'h4800_0013, 32'h200, 1'b1);
        idle(3);
        total++;
        if (strobeCycles.size() != n + 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=2", strobeCycles.size() - n);
        end else if (strobeCycles[n+1] - strobeCycles[n] != 17) begin
            bad++;
            $display("FAIL b2b_gap got=%0d want=17", strobeCycles[n+1] - strobeCycles[n]);
        end
        total++;
        if (q.size() != 0 || FrameSelect !== 5'd9) begin
            bad++;
            $display("FAIL b2b_final pending=%0d sel=%0d want 0/9", q.size(), FrameSelect);
        end
    endtask

    task automatic test_invalid;
        int n;
        n = strobeCycles.size();
        sendFrame(32'h1000_0019, 32'h300, 1'b1);
        idle(2);
        total++;
        if (ConfigError !== 1'b1 || strobeCycles.size() != n || FrameSelect !== 5'd2 || FrameData !== modelData) begin
            bad++;
            $display("FAIL invalid_frame err=%b strobes=%0d sel=%0d want 1/0/2", ConfigError, strobeCycles.size() - n, FrameSelect);
        end
        sendFrame(32'h3000_0014, 32'h400, 1'b1);
        idle(2);
        total++;
        if (strobeCycles.size() != n) begin
            bad++;
            $display("FAIL index20_strobe got=%0d want=0", strobeCycles.size() - n);
        end
        sendFrame(32'h2000_0007, 32'h500, 1'b1);
        idle(3);
        total++;
        if (ConfigError !== 1'b1 || strobeCycles.size() != n + 1 || q.size() != 0) begin
            bad++;
            $display("FAIL valid_after_error err=%b strobes=%0d want 1/1", ConfigError, strobeCycles.size() - n);
        end
    endtask

    task automatic test_desync;
        int n;
        n = strobeCycles.size();
        put(32'h0010_0000);
        total++;
        if (Synced !== 1'b0) begin
            bad++;
            $display("FAIL desync got=%b want=0", Synced);
        end
        sendFrame(32'h1800_0003, 32'hDEAD_0000, 1'b0);
        idle(2);
        total++;
        if (strobeCycles.size() != n || FrameData !== modelData || Synced !== 1'b0) begin
            bad++;
            $display("FAIL desync_ignore strobes=%0d synced=%b want 0/0", strobeCycles.size() - n, Synced);
        end
        put(SyncWord);
        sendFrame(32'h2800_0011, SyncWord - 32'd3, 1'b1);
        idle(3);
        total++;
        if (strobeCycles.size() != n + 1 || q.size() != 0) begin
            bad++;
            $display("FAIL syncword_as_data strobes=%0d want=1", strobeCycles.size() - n);
        end
    endtask

    task automatic test_midreset;
        int n;
        n = strobeCycles.size();
        put(SyncWord);
        put(32'h0800_0002);
        for (int k = 0; k < 7; k++) put(32'h700 + k);
        #2 resetn = 1'b0;
        #1;
        total++;
        if ({FrameData, FrameAddress, FrameSelect, FrameStrobe, Synced, ConfigError} !== '0) begin
            bad++;
            $display("FAIL async_reset sel=%0d synced=%b err=%b want all zero", FrameSelect, Synced, ConfigError);
        end
        modelData = '0;
        idle(2);
        resetn = 1'b1;
        idle(1);
        sendFrame(32'h1800_0003, 32'h55, 1'b0);
        idle(3);
        total++;
        if (strobeCycles.size() != n || Synced !== 1'b0 || FrameData !== '0 || q.size() != 0) begin
            bad++;
            $display("FAIL post_reset_nosync strobes=%0d synced=%b want 0/0", strobeCycles.size() - n, Synced);
        end
    endtask

    initial begin
        @(posedge CLK);
        #1;
        test_reset;
        test_single;
        test_back_to_back;
        test_invalid;
        test_desync;
        test_midreset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
